// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, drives the instruction-memory address and
// presents instruction/PC/bubble flag to the IF/ID register.
module instruction_fetch_unit #(
   parameter int                    PC_WIDTH     = 32,
   parameter logic [PC_WIDTH-1:0]   RESET_PC     = '0,
   parameter int                    FLUSH_CYCLES = 2,
   parameter logic [31:0]           NOP_INSTR    = 32'hE1A00000
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                stall,
   input  logic                branchTaken,
   input  logic [PC_WIDTH-1:0] branchTarget,
   output logic [PC_WIDTH-1:0] imemAddr,
   input  logic [31:0]         imemData,
   output logic [31:0]         instructionOUT,
   output logic [PC_WIDTH-1:0] pcValOUT,
   output logic                noopOUT
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2
   } state_t;

   localparam logic [2:0]          FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);
   localparam logic [PC_WIDTH-1:0] PC_STEP    = PC_WIDTH'(4);
   localparam logic [PC_WIDTH-1:0] ALIGN_MASK = ~PC_WIDTH'(3);

   state_t              state, state_n;
   logic [PC_WIDTH-1:0] pc, pc_n;
   logic [2:0]          flushCnt, flushCnt_n;
   logic [PC_WIDTH-1:0] target;

   assign target = branchTarget & ALIGN_MASK;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         pc       <= RESET_PC;
         flushCnt <= 3'd0;
      end else begin
         state    <= state_n;
         pc       <= pc_n;
         flushCnt <= flushCnt_n;
      end
   end

   // Branch beats stall in both RUN and FLUSH; a stall freezes the bubble count.
   always_comb begin
      state_n    = state;
      pc_n       = pc;
      flushCnt_n = flushCnt;
      case (state)
         IDLE: begin
            state_n = RUN;
         end
         RUN: begin
            if (branchTaken) begin
               pc_n       = target;
               state_n    = FLUSH;
               flushCnt_n = FLUSH_LOAD;
            end else if (!stall) begin
               pc_n = pc + PC_STEP;
            end
         end
         FLUSH: begin
            if (branchTaken) begin
               pc_n       = target;
               flushCnt_n = FLUSH_LOAD;
            end else if (!stall) begin
               if (flushCnt == 3'd0) begin
                  state_n = RUN;
               end else begin
                  flushCnt_n = flushCnt - 3'd1;
               end
            end
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   assign imemAddr       = pc;
   assign pcValOUT       = pc;
   assign noopOUT        = (state != RUN);
   assign instructionOUT = noopOUT ? NOP_INSTR : imemData;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench for instruction_fetch_unit: expected fetch triples are
// queued with the stimulus and compared on the falling clock edge.
module tb_instruction_fetch_unit;

   localparam logic [31:0] NOP = 32'hE1A00000;

   typedef struct packed {
      logic [31:0] pc;
      logic        noop;
      logic [31:0] ins;
   } exp_t;

   typedef struct packed {
      logic        st;
      logic        br;
      logic [31:0] tg;
   } stim_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        stall = 1'b0;
   logic        branchTaken = 1'b0;
   logic [31:0] branchTarget = '0;

   logic [31:0] imemAddr_a, imemData_a, instructionOUT_a, pcValOUT_a;
   logic        noopOUT_a;
   logic [31:0] imemAddr_b, imemData_b, instructionOUT_b, pcValOUT_b;
   logic        noopOUT_b;

   int checks = 0;
   int errors = 0;
   exp_t sb[$];

   always #5 clk = ~clk;

   assign imemData_a = imemAddr_a | 32'hE0000000;
   assign imemData_b = imemAddr_b | 32'hE0000000;

   instruction_fetch_unit #(
      .PC_WIDTH(32), .RESET_PC(32'h0),
      .FLUSH_CYCLES(2), .NOP_INSTR(NOP)
   ) dut_a (
      .clk(clk), .reset(reset), .stall(stall),
      .branchTaken(branchTaken), .branchTarget(branchTarget),
      .imemAddr(imemAddr_a), .imemData(imemData_a),
      .instructionOUT(instructionOUT_a), .pcValOUT(pcValOUT_a),
      .noopOUT(noopOUT_a)
   );

   instruction_fetch_unit #(
      .PC_WIDTH(32), .RESET_PC(32'hFFFFFFF8),
      .FLUSH_CYCLES(2), .NOP_INSTR(NOP)
   ) dut_b (
      .clk(clk), .reset(reset), .stall(stall),
      .branchTaken(branchTaken), .branchTarget(branchTarget),
      .imemAddr(imemAddr_b), .imemData(imemData_b),
      .instructionOUT(instructionOUT_b), .pcValOUT(pcValOUT_b),
      .noopOUT(noopOUT_b)
   );

   function automatic exp_t mk(logic [31:0] pc, logic noop);
      exp_t e;
      e.pc   = pc;
      e.noop = noop;
      e.ins  = noop ? NOP : (pc | 32'hE0000000);
      return e;
   endfunction

   function automatic stim_t s(logic st, logic br, logic [31:0] tg);
      stim_t x;
      x.st = st;
      x.br = br;
      x.tg = tg;
      return x;
   endfunction

   task automatic test_reset();
      stim_t sq[$];
      exp_t  e;
      stim_t x;
      int    c = 0;
      reset = 1'b1;
      @(negedge clk);
      checks++;
      if ({pcValOUT_a, noopOUT_a, instructionOUT_a} !== {32'h0, 1'b1, NOP}
          || imemAddr_a !== 32'h0) begin
         errors++;
         $display("FAIL reset_state got pc=%h noop=%b ins=%h exp pc=0 noop=1 ins=%h",
                  pcValOUT_a, noopOUT_a, instructionOUT_a, NOP);
      end
      @(posedge clk);
      #1 reset = 1'b0;
      sb.push_back(mk(32'h0, 1'b1)); sq.push_back(s(0, 0, 0));
      sb.push_back(mk(32'h0, 1'b0)); sq.push_back(s(0, 0, 0));
      sb.push_back(mk(32'h4, 1'b0)); sq.push_back(s(0, 0, 0));
      sb.push_back(mk(32'h8, 1'b0)); sq.push_back(s(0, 0, 0));
      while (sq.size() > 0) begin
         @(negedge clk);
         e = sb.pop_front();
         x = sq.pop_front();
         checks++;
         if ({pcValOUT_a, noopOUT_a, instructionOUT_a} !== e || imemAddr_a !== e.pc) begin
            errors++;
            $display("FAIL startup c%0d got pc=%h noop=%b ins=%h exp pc=%h noop=%b ins=%h",
                     c, pcValOUT_a, noopOUT_a, instructionOUT_a, e.pc, e.noop, e.ins);
         end
         stall = x.st; branchTaken = x.br; branchTarget = x.tg;
         c++;
      end
   endtask

   task automatic test_stall();
      stim_t sq[$];
      exp_t  e;
      stim_t x;
      int    c = 0;
      sb.push_back(mk(32'h0C, 1'b0)); sq.push_back(s(0, 0, 0));
      sb.push_back(mk(32'h10, 1'b0)); sq.push_back(s(1, 0, 0));
      sb.push_back(mk(32'h10, 1'b0)); sq.push_back(s(1, 0, 0));
      sb.push_back(mk(32'h10, 1'b0)); sq.push_back(s(1, 0, 0));
      sb.push_back(mk(32'h10, 1'b0)); sq.push_back(s(0, 0, 0));
      sb.push_back(mk(32'h14, 1'b0)); sq.push_back(s(0, 0, 0));
      while (sq.size() > 0) begin
         @(negedge clk);
         e = sb.pop_front();
         x = sq.pop_front();
         checks++;
         if ({pcValOUT_a, noopOUT_a, instructionOUT_a} !== e || imemAddr_a !== e.pc) begin
            errors++;
            $display("FAIL stall c%0d got pc=%h noop=%b ins=%h exp pc=%h noop=%b ins=%h",
                     c, pcValOUT_a, noopOUT_a, instructionOUT_a, e.pc, e.noop, e.ins);
         end
         stall = x.st; branchTaken = x.br; branchTarget = x.tg;
         c++;
      end
   endtask

   task automatic test_branch();
      stim_t sq[$];
      exp_t  e;
      stim_t x;
      int    c = 0;
      sb.push_back(mk(32'h18, 1'b0));  sq.push_back(s(0, 0, 0));
      sb.push_back(mk(32'h1C, 1'b0));  sq.push_back(s(0, 0, 0));
      sb.push_back(mk(32'h20, 1'b0));  sq.push_back(s(0, 1, 32'h103));
      sb.push_back(mk(32'h100, 1'b1)); sq.push_back(s(0, 0, 0));
      sb.push_back(mk(32'h100, 1'b1)); sq.push_back(s(0, 0, 0));
      sb.push_back(mk(32'h100, 1'b0)); sq.push_back(s(0, 0, 0));
      sb.push_back(mk(32'h104, 1'b0)); sq.push_back(s(0, 0, 0));
      while (sq.size() > 0) begin
         @(negedge clk);
         e = sb.pop_front();
         x = sq.pop_front();
         checks++;
         if ({pcValOUT_a, noopOUT_a, instructionOUT_a} !== e || imemAddr_a !== e.pc) begin
            errors++;
            $display("FAIL branch c%0d got pc=%h noop=%b ins=%h exp pc=%h noop=%b ins=%h",
                     c, pcValOUT_a, noopOUT_a, instructionOUT_a, e.pc, e.noop, e.ins);
         end
         stall = x.st; branchTaken = x.br; branchTarget = x.tg;
         c++;
      end
   endtask

   task automatic test_back_to_back();
      stim_t sq[$];
      exp_t  e;
      stim_t x;
      int    c = 0;
      sb.push_back(mk(32'h108, 1'b0)); sq.push_back(s(0, 1, 32'h40));
      sb.push_back(mk(32'h40, 1'b1));  sq.push_back(s(0, 0, 0));
      sb.push_back(mk(32'h40, 1'b1));  sq.push_back(s(0, 0, 0));
      sb.push_back(mk(32'h40, 1'b0));  sq.push_back(s(0, 1, 32'h300));
      sb.push_back(mk(32'h300, 1'b1)); sq.push_back(s(0, 1, 32'h202));
      sb.push_back(mk(32'h200, 1'b1)); sq.push_back(s(0, 0, 0));
      sb.push_back(mk(32'h200, 1'b1)); sq.push_back(s(0, 0, 0));
      sb.push_back(mk(32'h200, 1'b0)); sq.push_back(s(0, 0, 0));
      sb.push_back(mk(32'h204, 1'b0)); sq.push_back(s(1, 1, 32'h80));
      sb.push_back(mk(32'h80, 1'b1));  sq.push_back(s(0, 0, 0));
      sb.push_back(mk(32'h80, 1'b1));  sq.push_back(s(1, 0, 0));
      sb.push_back(mk(32'h80, 1'b1));  sq.push_back(s(0, 0, 0));
      sb.push_back(mk(32'h80, 1'b0));  sq.push_back(s(0, 0, 0));
      sb.push_back(mk(32'h84, 1'b0));  sq.push_back(s(0, 0, 0));
      while (sq.size() > 0) begin
         @(negedge clk);
         e = sb.pop_front();
         x = sq.pop_front();
         checks++;
         if ({pcValOUT_a, noopOUT_a, instructionOUT_a} !== e || imemAddr_a !== e.pc) begin
            errors++;
            $display("FAIL back_to_back c%0d got pc=%h noop=%b ins=%h exp pc=%h noop=%b ins=%h",
                     c, pcValOUT_a, noopOUT_a, instructionOUT_a, e.pc, e.noop, e.ins);
         end
         stall = x.st; branchTaken = x.br; branchTarget = x.tg;
         c++;
      end
   endtask

   task automatic test_wrap();
      stim_t sq[$];
      exp_t  e;
      stim_t x;
      int    c = 0;
      @(posedge clk);
      #1 reset = 1'b1;
      #1;
      checks++;
      if ({pcValOUT_b, noopOUT_b, instructionOUT_b} !== {32'hFFFFFFF8, 1'b1, NOP}) begin
         errors++;
         $display("FAIL wrap_reset got pc=%h noop=%b ins=%h exp pc=fffffff8 noop=1 ins=%h",
                  pcValOUT_b, noopOUT_b, instructionOUT_b, NOP);
      end
      @(posedge clk);
      #1 reset = 1'b0;
      sb.push_back(mk(32'hFFFFFFF8, 1'b1)); sq.push_back(s(0, 0, 0));
      sb.push_back(mk(32'hFFFFFFF8, 1'b0)); sq.push_back(s(0, 0, 0));
      sb.push_back(mk(32'hFFFFFFFC, 1'b0)); sq.push_back(s(0, 0, 0));
      sb.push_back(mk(32'h0, 1'b0));        sq.push_back(s(0, 0, 0));
      sb.push_back(mk(32'h4, 1'b0));        sq.push_back(s(0, 0, 0));
      while (sq.size() > 0) begin
         @(negedge clk);
         e = sb.pop_front();
         x = sq.pop_front();
         checks++;
         if ({pcValOUT_b, noopOUT_b, instructionOUT_b} !== e || imemAddr_b !== e.pc) begin
            errors++;
            $display("FAIL wrap c%0d got pc=%h noop=%b ins=%h exp pc=%h noop=%b ins=%h",
                     c, pcValOUT_b, noopOUT_b, instructionOUT_b, e.pc, e.noop, e.ins);
         end
         stall = x.st; branchTaken = x.br; branchTarget = x.tg;
         c++;
      end
   endtask

   task automatic test_reset_flush();
      stim_t sq[$];
      exp_t  e;
      stim_t x;
      int    c = 0;
      @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      sb.push_back(mk(32'h0, 1'b1));   sq.push_back(s(0, 0, 0));
      sb.push_back(mk(32'h0, 1'b0));   sq.push_back(s(0, 1, 32'h500));
      sb.push_back(mk(32'h500, 1'b1)); sq.push_back(s(0, 0, 0));
      while (sq.size() > 0) begin
         @(negedge clk);
         e = sb.pop_front();
         x = sq.pop_front();
         checks++;
         if ({pcValOUT_a, noopOUT_a, instructionOUT_a} !== e || imemAddr_a !== e.pc) begin
            errors++;
            $display("FAIL pre_flush_reset c%0d got pc=%h noop=%b ins=%h exp pc=%h noop=%b ins=%h",
                     c, pcValOUT_a, noopOUT_a, instructionOUT_a, e.pc, e.noop, e.ins);
         end
         stall = x.st; branchTaken = x.br; branchTarget = x.tg;
         c++;
      end
      @(posedge clk);
      #2 reset = 1'b1;
      #1;
      checks++;
      if ({pcValOUT_a, noopOUT_a, instructionOUT_a} !== {32'h0, 1'b1, NOP}
          || imemAddr_a !== 32'h0) begin
         errors++;
         $display("FAIL async_reset got pc=%h noop=%b ins=%h exp pc=0 noop=1 ins=%h",
                  pcValOUT_a, noopOUT_a, instructionOUT_a, NOP);
      end
      @(posedge clk);
      #1 reset = 1'b0;
      c = 0;
      sb.push_back(mk(32'h0, 1'b1)); sq.push_back(s(0, 0, 0));
      sb.push_back(mk(32'h0, 1'b0)); sq.push_back(s(0, 0, 0));
      sb.push_back(mk(32'h4, 1'b0)); sq.push_back(s(0, 0, 0));
      while (sq.size() > 0) begin
         @(negedge clk);
         e = sb.pop_front();
         x = sq.pop_front();
         checks++;
         if ({pcValOUT_a, noopOUT_a, instructionOUT_a} !== e || imemAddr_a !== e.pc) begin
            errors++;
            $display("FAIL post_reset c%0d got pc=%h noop=%b ins=%h exp pc=%h noop=%b ins=%h",
                     c, pcValOUT_a, noopOUT_a, instructionOUT_a, e.pc, e.noop, e.ins);
         end
         stall = x.st; branchTaken = x.br; branchTarget = x.tg;
         c++;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_stall();
      test_branch();
      test_back_to_back();
      test_wrap();
      test_reset_flush();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
